// File: rtl/prbs4_checker.sv
// prbs4_checker: receive-side checker for the x^4+x^3+1 PRBS stream.
// Hunts for the sequence by predicting each received bit from the previous
// four, declares lock after LOCK_CNT consecutive good predictions, then runs a
// free-running local LFSR and counts mismatches. LOSS_CNT consecutive
// mismatches drop lock and restart the hunt.
module prbs4_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t         state;
    logic [3:0]     hist;   // hist[0] is the newest bit
    logic [2:0]     fill;
    logic [MW-1:0]  match;
    logic [LW-1:0]  miss;
    logic           pred;

    // Next-bit prediction from the recurrence b[n] = b[n-3] ^ b[n-4]
    always_comb begin
        pred = hist[3] ^ hist[2];
    end

    // Hunt/lock state machine, local LFSR, error flag and saturating counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        hist <= {hist[2:0], din};
                        if (fill != 3'd4) begin
                            fill <= fill + 3'd1;
                        end else if ((din == pred) && (|hist)) begin
                            match <= match + MW'(1);
                            if (match == MATCH_LAST) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running: the received bit never enters hist,
                        // so one flipped bit costs exactly one error.
                        hist <= {hist[2:0], pred};
                        if (din != pred) begin
                            err_pulse <= 1'b1;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + ERR_W'(1);
                            if (miss == MISS_LAST) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                                fill   <= '0;
                                match  <= '0;
                                miss   <= '0;
                            end else begin
                                miss <= miss + LW'(1);
                            end
                        end else begin
                            miss <= '0;
                        end
                    end
                endcase
            end
            // Clear overrides any increment on the same edge.
            if (clear)
                err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_prbs4_checker.sv
// tb_prbs4_checker: directed checks of prbs4_checker against the reference
// PRBS4 stream, with a second instance at ERR_W = 2 for saturation.
module tb_prbs4_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       clear;
    logic       locked, err_pulse;
    logic [7:0] err_cnt;
    logic       locked2, err_pulse2;
    logic [1:0] err_cnt2;

    int errors = 0;
    int checks = 0;
    int ph     = 0;
    // Reference stream, index 0 first: 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1
    logic [14:0] ref_seq = 15'b100011110101100;

    prbs4_checker dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    prbs4_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive the next reference bit (optionally inverted); sample 1 ns after the edge
    task automatic step(input logic inv, input logic v);
        @(negedge clk);
        din       = ref_seq[ph] ^ inv;
        din_valid = v;
        @(posedge clk);
        #1;
        if (v) ph = (ph == 14) ? 0 : ph + 1;
    endtask

    task automatic step_raw(input logic b, input logic v);
        @(negedge clk);
        din       = b;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ph  = 0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; clear = 1'b0;

        // Reset state
        #1;
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: acquisition on the 12th valid bit, then clean tracking
        for (int i = 1; i <= 11; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("t1_hunt_locked_%0d", i), locked, 0);
        end
        step(1'b0, 1'b1);
        check("t1_locked_at_12", locked, 1);
        check("t1_err_cnt_at_lock", err_cnt, 0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("t1_err_pulse_%0d", i), err_pulse, 0);
            check($sformatf("t1_locked_%0d", i), locked, 1);
        end
        check("t1_err_cnt_end", err_cnt, 0);

        // 2: single bit error
        step(1'b1, 1'b1);
        check("t2_err_pulse", err_pulse, 1);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_locked", locked, 1);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("t2_no_err_%0d", i), err_pulse, 0);
        end
        check("t2_err_cnt_end", err_cnt, 1);
        check("t2_locked_end", locked, 1);

        // clear pulse while locked
        clear = 1'b1;
        step(1'b0, 1'b1);
        clear = 1'b0;
        check("clr_err_cnt", err_cnt, 0);
        check("clr_locked", locked, 1);

        // 3: four consecutive errors drop lock, then reacquire
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("t3_err_pulse_%0d", i), err_pulse, 1);
            check($sformatf("t3_err_cnt_%0d", i), err_cnt, i);
            check($sformatf("t3_locked_%0d", i), locked, (i < 4) ? 1 : 0);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("t3_relock_%0d", i), locked, (i == 12) ? 1 : 0);
            check($sformatf("t3_hunt_pulse_%0d", i), err_pulse, 0);
        end
        check("t3_err_cnt_kept", err_cnt, 4);

        // 6: saturation, clear, clear-vs-error, async reset
        clear = 1'b1;
        step(1'b0, 1'b1);
        clear = 1'b0;
        check("t6_pre_clear", err_cnt, 0);
        check("t6_pre_clear2", err_cnt2, 0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("t6_pulse_%0d", k), err_pulse2, 1);
            check($sformatf("t6_cnt8_%0d", k), err_cnt, k);
            check($sformatf("t6_cnt2_%0d", k), err_cnt2, (k < 3) ? k : 3);
            for (int j = 0; j < 3; j++) step(1'b0, 1'b1);
            check($sformatf("t6_locked2_%0d", k), locked2, 1);
        end
        clear = 1'b1;
        step(1'b0, 1'b1);
        clear = 1'b0;
        check("t6_clear_cnt2", err_cnt2, 0);
        check("t6_clear_cnt8", err_cnt, 0);
        check("t6_clear_locked", locked, 1);
        clear = 1'b1;
        step(1'b1, 1'b1);
        clear = 1'b0;
        check("t6_clr_err_pulse", err_pulse, 1);
        check("t6_clr_err_cnt", err_cnt, 0);
        step(1'b0, 1'b1);
        check("t6_after_pulse", err_pulse, 0);
        step(1'b1, 1'b1);
        check("t6_pre_rst_cnt", err_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_locked", locked, 0);
        check("t6_async_err_cnt", err_cnt, 0);
        check("t6_async_err_pulse", err_pulse, 0);
        check("t6_async_err_cnt2", err_cnt2, 0);
        @(negedge clk);
        rst = 1'b0;

        // 4: all-zero stream never locks
        for (int i = 0; i < 60; i++) begin
            step_raw(1'b0, 1'b1);
            check($sformatf("t4_locked_%0d", i), locked, 0);
        end
        check("t4_err_cnt", err_cnt, 0);

        // 5: alternating din_valid; invalid cycles carry corrupted data
        do_reset();
        for (int v = 1; v <= 12; v++) begin
            step(1'b0, 1'b1);
            check($sformatf("t5_valid_locked_%0d", v), locked, (v == 12) ? 1 : 0);
            step(1'b1, 1'b0);
            check($sformatf("t5_idle_locked_%0d", v), locked, (v == 12) ? 1 : 0);
            check($sformatf("t5_idle_pulse_%0d", v), err_pulse, 0);
        end
        step(1'b1, 1'b1);
        check("t5_err_pulse", err_pulse, 1);
        check("t5_err_cnt", err_cnt, 1);
        step(1'b1, 1'b0);
        check("t5_idle_pulse_drop", err_pulse, 0);
        check("t5_idle_err_cnt", err_cnt, 1);
        check("t5_idle_locked", locked, 1);
        step(1'b0, 1'b1);
        check("t5_resume_pulse", err_pulse, 0);
        check("t5_resume_err_cnt", err_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prbs4_checker.md
Name: prbs4_checker

Overview:
- Receive-side companion to the team's 4-bit loadable LFSR generator.
- Takes the serial PRBS stream (x^4+x^3+1, period 15, recurrence b[n] = b[n-3] XOR b[n-4]), self-synchronises to it, then tracks it with a free-running local LFSR.
- Flags and counts bit errors and reports lock status.
- Sits at the far end of a serial link or loopback path used for link/BIST testing.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions in HUNT required to declare lock.
- LOSS_CNT, 4: consecutive mispredictions in LOCKED that drop lock.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  received serial bit.
- din_valid  input  1  din is sampled only on edges where this is 1.
- clear  input  1  synchronous clear of err_cnt.
- locked  output  1  1 while in LOCKED state.
- err_pulse  output  1  one-cycle flag: the bit sampled on the previous edge was an error while locked.
- err_cnt  output  ERR_W  saturating count of errors detected in LOCKED.

Behaviour:
- Reset (async, immediate):
  - State = HUNT.
  - hist = 0, fill = 0, match = 0, miss = 0.
  - locked = 0, err_pulse = 0, err_cnt = 0.
- Prediction: pred = hist[3] XOR hist[2]. hist[0] holds the newest bit.
- All outputs are registered. Edges with din_valid = 0 change nothing except err_pulse, which is forced to 0.
- HUNT, on each valid edge:
  - hist <= {hist[2:0], din} (loads the received bit).
  - While fill < 4: fill increments; no comparison is made.
  - Once fill = 4: if din == pred and hist != 0, match increments; otherwise match <= 0.
  - An all-zero history never counts as a match, so an all-zero stream can never lock.
  - When match reaches LOCK_CNT, go to LOCKED; locked is 1 after that same edge.
  - With the defaults, locked rises on the edge sampling the 12th valid bit.
- LOCKED, on each valid edge:
  - hist <= {hist[2:0], pred} (free-running, so a single bit error costs exactly one error).
  - If din != pred: err_pulse <= 1, err_cnt increments, saturating at all ones, and miss increments.
  - If din == pred: err_pulse <= 0 and miss <= 0.
  - When miss reaches LOSS_CNT, return to HUNT on that edge: locked <= 0 and fill, match, miss <= 0.
  - The LOSS_CNT-th error is still counted.
- err_cnt is retained across HUNT/LOCKED transitions. It only clears on rst or clear.
- Simultaneous clear and error: clear wins, so err_cnt = 0; err_pulse still fires.
- clear has no effect on state, hist, or locked.
- Reset asserted mid-operation returns every register to its reset value with no clock required.
- The local LFSR cannot reach zero in LOCKED, because lock is only achieved from a nonzero history.

Test Plan:
- Reference stream: period 15, repeating 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 (generator seeded 0001).
- 1. Reset, then drive the reference stream with din_valid = 1 continuously → locked = 0 through the 11th bit, locked = 1 after the 12th bit's edge; err_cnt = 0 and err_pulse = 0 throughout 100 further bits.
- 2. After lock, invert exactly one bit → err_pulse high for exactly one cycle; err_cnt = 1; locked stays 1; the following 50 correct bits produce no further errors.
- 3. After lock, invert 4 consecutive bits, then resume the correct stream → err_cnt = 4, locked falls after the 4th inverted bit; locked rises again 12 valid bits later; err_cnt stays 4.
- 4. Reset, then drive din = 0 constantly for 60 cycles → locked never rises; err_cnt = 0.
- 5. Reference stream with din_valid toggling 1,0,1,0 → lock after 12 valid bits (about 24 cycles); invalid cycles cause no state change.
- 6. Saturation and clear:
  - With ERR_W = 2, inject 6 isolated errors while locked → err_cnt = 3.
  - Pulse clear → err_cnt = 0 next cycle, locked unchanged.
  - Assert rst asynchronously while locked → locked = 0 and err_cnt = 0 before the next clk edge.
